// File: rtl/branch_resolve_queue_if.sv
// Fetch/EX-facing bundle for the branch resolve queue: prediction enqueue,
// EX resolution, external flush, and the redirect/statistics returned to fetch.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

interface branch_resolve_queue_if #(
   parameter int AW        = `ADDR_WIDTH,
   parameter int CNT_WIDTH = 32
);
   logic                 fetch_branch_valid;
   logic [AW-1:0]        fetch_pc;
   logic [1:0]           predictor;
   logic [AW-1:0]        fetch_pred_target;
   logic                 branch_ex;
   logic [AW-1:0]        branch_pc_ex;
   logic                 branch_taken_ex;
   logic [AW-1:0]        branch_target_ex;
   logic                 flush_ext;
   logic                 fetch_stall;
   logic                 mispredict;
   logic [AW-1:0]        redirect_pc;
   logic [CNT_WIDTH-1:0] branch_cnt;
   logic [CNT_WIDTH-1:0] mispredict_cnt;

   modport master (
      output fetch_branch_valid, fetch_pc, predictor, fetch_pred_target,
      output branch_ex, branch_pc_ex, branch_taken_ex, branch_target_ex, flush_ext,
      input  fetch_stall, mispredict, redirect_pc, branch_cnt, mispredict_cnt
   );

   modport slave (
      input  fetch_branch_valid, fetch_pc, predictor, fetch_pred_target,
      input  branch_ex, branch_pc_ex, branch_taken_ex, branch_target_ex, flush_ext,
      output fetch_stall, mispredict, redirect_pc, branch_cnt, mispredict_cnt
   );
endinterface

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time branch predictions; checks each against the EX
// outcome, issues a registered one-cycle redirect on mismatch, and counts both.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module branch_resolve_queue #(
   parameter int DEPTH     = 4,
   parameter int PTR_WIDTH = $clog2(DEPTH),
   parameter int CNT_WIDTH = 32
) (
   input logic                   cpu_clk,
   input logic                   cpu_rstn,
   branch_resolve_queue_if.slave bus
);
   localparam int AW = `ADDR_WIDTH;
   localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);
   localparam logic [PTR_WIDTH-1:0] PTR_ZERO = PTR_WIDTH'(0);
   localparam logic [PTR_WIDTH:0]   OCC_ONE  = (PTR_WIDTH+1)'(1);
   localparam logic [PTR_WIDTH:0]   OCC_ZERO = (PTR_WIDTH+1)'(0);
   localparam logic [PTR_WIDTH:0]   OCC_FULL = (PTR_WIDTH+1)'(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
   localparam logic [AW-1:0]        PC_STEP  = AW'(4);
   localparam logic [AW-1:0]        PC_ZERO  = AW'(0);

   logic [AW-1:0]        pc_mem_r    [DEPTH];
   logic                 taken_mem_r [DEPTH];
   logic [AW-1:0]        tgt_mem_r   [DEPTH];
   logic [PTR_WIDTH-1:0] rd_ptr_r;
   logic [PTR_WIDTH-1:0] wr_ptr_r;
   logic [PTR_WIDTH:0]   occ_r;
   logic                 mispredict_r;
   logic [AW-1:0]        redirect_pc_r;
   logic [CNT_WIDTH-1:0] branch_cnt_r;
   logic [CNT_WIDTH-1:0] mispredict_cnt_r;

   logic full_s, empty_s, resolve_s, mismatch_s, flush_now_s, enq_s, pop_s;
   logic [AW-1:0] head_pc_s, head_tgt_s;
   logic          head_taken_s;
   logic          unused_pred_s;

   // Only the direction bit of the predictor counter matters here.
   assign unused_pred_s = bus.predictor[0];

   // Queue status, head decode, and resolve/mismatch/enqueue qualification.
   always_comb begin
      full_s       = (occ_r == OCC_FULL);
      empty_s      = (occ_r == OCC_ZERO);
      head_pc_s    = pc_mem_r[rd_ptr_r];
      head_taken_s = taken_mem_r[rd_ptr_r];
      head_tgt_s   = tgt_mem_r[rd_ptr_r];
      // A resolve in the redirect cycle belongs to the wrong path.
      resolve_s    = bus.branch_ex && !mispredict_r;
      mismatch_s   = 1'b0;
      if (resolve_s) begin
         mismatch_s = empty_s
                   || (head_pc_s != bus.branch_pc_ex)
                   || (head_taken_s != bus.branch_taken_ex)
                   || (head_taken_s && bus.branch_taken_ex && (head_tgt_s != bus.branch_target_ex));
      end else begin
         mismatch_s = 1'b0;
      end
      flush_now_s = mismatch_s || bus.flush_ext;
      enq_s       = bus.fetch_branch_valid && !full_s && !flush_now_s;
      pop_s       = resolve_s && !empty_s;
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge cpu_clk) begin
      if (enq_s) begin
         pc_mem_r[wr_ptr_r]    <= bus.fetch_pc;
         taken_mem_r[wr_ptr_r] <= bus.predictor[1];
         tgt_mem_r[wr_ptr_r]   <= bus.fetch_pred_target;
      end
   end

   // Pointers and occupancy; any flush wins over same-cycle enqueue/pop.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         rd_ptr_r <= PTR_ZERO;
         wr_ptr_r <= PTR_ZERO;
         occ_r    <= OCC_ZERO;
      end else if (flush_now_s) begin
         rd_ptr_r <= PTR_ZERO;
         wr_ptr_r <= PTR_ZERO;
         occ_r    <= OCC_ZERO;
      end else begin
         if (enq_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
         case ({enq_s, pop_s})
            2'b10:   occ_r <= occ_r + OCC_ONE;
            2'b01:   occ_r <= occ_r - OCC_ONE;
            default: occ_r <= occ_r;
         endcase
      end
   end

   // Registered redirect pulse and statistics.
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         mispredict_r     <= 1'b0;
         redirect_pc_r    <= PC_ZERO;
         branch_cnt_r     <= CNT_ZERO;
         mispredict_cnt_r <= CNT_ZERO;
      end else begin
         mispredict_r <= mismatch_s;
         if (mismatch_s) begin
            redirect_pc_r    <= bus.branch_taken_ex ? bus.branch_target_ex : (bus.branch_pc_ex + PC_STEP);
            mispredict_cnt_r <= mispredict_cnt_r + CNT_ONE;
         end
         if (resolve_s) branch_cnt_r <= branch_cnt_r + CNT_ONE;
      end
   end

   assign bus.fetch_stall    = full_s;
   assign bus.mispredict     = mispredict_r;
   assign bus.redirect_pc    = redirect_pc_r;
   assign bus.branch_cnt     = branch_cnt_r;
   assign bus.mispredict_cnt = mispredict_cnt_r;
endmodule

// File: doc/branch_resolve_queue.md
Name: branch_resolve_queue

Overview:
- Execute-side partner of the fetch-side 2-level branch predictor.
- Records each prediction issued at fetch in an in-order queue: PC, predicted direction and predicted target.
- When the branch resolves in EX, pops the oldest entry and compares it with the actual outcome.
- Produces a registered mispredict/redirect to fetch, drops all wrong-path entries, and keeps branch and mispredict statistics.

Parameters:
- DEPTH, 4, number of in-flight branch entries; power of 2, minimum 2.
- PTR_WIDTH, $clog2(DEPTH), pointer width.
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- cpu_clk  input  1  core clock; all state changes on the rising edge.
- cpu_rstn  input  1  asynchronous active-low reset.
- fetch_branch_valid  input  1  fetch has a predecoded branch this cycle.
- fetch_pc  input  `ADDR_WIDTH  PC of that branch.
- predictor  input  2  2-bit counter from the predictor; bit[1] = predicted taken.
- fetch_pred_target  input  `ADDR_WIDTH  predicted target; used only when predicted taken.
- branch_ex  input  1  a branch resolves in EX this cycle.
- branch_pc_ex  input  `ADDR_WIDTH  PC of the resolving branch.
- branch_taken_ex  input  1  actual direction.
- branch_target_ex  input  `ADDR_WIDTH  actual target.
- flush_ext  input  1  trap/exception flush; clears the queue.
- fetch_stall  output  1  queue full; fetch must hold its branch.
- mispredict  output  1  one-cycle pulse requesting a fetch redirect.
- redirect_pc  output  `ADDR_WIDTH  correct next PC; valid while mispredict = 1.
- branch_cnt  output  CNT_WIDTH  branches resolved.
- mispredict_cnt  output  CNT_WIDTH  mispredicts detected.

Behaviour:
- Reset values:
  - Read and write pointers and occupancy = 0.
  - fetch_stall = 0, mispredict = 0, redirect_pc = 0.
  - branch_cnt = 0, mispredict_cnt = 0.
  - Entry contents are don't-care.
- Occupancy ranges 0..DEPTH.
  - fetch_stall = (occupancy == DEPTH), combinational from registered occupancy.
  - Full blocks enqueue even if a dequeue happens in the same cycle.
- Enqueue: when fetch_branch_valid && !fetch_stall && !flush_now.
  - Stores fetch_pc, predictor[1] and fetch_pred_target at the write pointer.
  - Write pointer increments, wrapping modulo DEPTH.
- Resolve: when branch_ex && !mispredict.
  - A branch_ex arriving in the cycle mispredict is high is wrong-path and is ignored: no pop, no count.
  - The head entry is popped and branch_cnt increments (wrapping).
  - A mismatch is any of:
    - queue empty;
    - head PC != branch_pc_ex;
    - head taken != branch_taken_ex;
    - both taken and head target != branch_target_ex.
- Mispredict path (mismatch):
  - On the same edge: all pointers and occupancy clear, and any same-cycle enqueue is dropped.
  - Registered outputs: mispredict = 1 for exactly one cycle, with redirect_pc = branch_taken_ex ? branch_target_ex : branch_pc_ex + 4.
  - mispredict_cnt increments (wrapping).
  - flush_now = mismatch || flush_ext.
- Latency: mispredict and redirect_pc appear 1 cycle after the branch_ex cycle.
- Correct prediction: pop only; mispredict stays 0; redirect_pc holds its last value.
- Simultaneous enqueue and correct resolve (not full): read and write pointers both advance; occupancy is unchanged.
- flush_ext:
  - Clears the queue on that edge; same-cycle enqueue is dropped.
  - Does not assert mispredict.
  - If a resolve happens in the same cycle, it is still counted and still checked.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any pending mispredict pulse is lost.

Test Plan:
- Reset, then enqueue pc=0x100, predictor=2'b11, target=0x200; resolve branch_pc_ex=0x100, taken=1, target=0x200 -> mispredict stays 0, branch_cnt=1, occupancy 0.
- Enqueue pc=0x100, predictor=2'b01; resolve taken=1, target=0x180 -> next cycle mispredict=1 for one cycle, redirect_pc=0x180, mispredict_cnt=1.
- Enqueue pc=0x300, predictor=2'b10 (predict taken); resolve taken=0 -> redirect_pc=0x304; a branch_ex in the mispredict cycle is ignored and branch_cnt stays 1.
- Enqueue 4 branches (DEPTH=4) -> fetch_stall=1; a 5th fetch_branch_valid is not stored; a same-cycle correct resolve does not admit it; fetch_stall=0 the following cycle.
- Queue holds 3 entries; the first resolve mispredicts while fetch_branch_valid=1 -> occupancy 0 after the edge; the next resolve with no new enqueue is flagged mispredict (empty queue).
- flush_ext with 2 entries queued -> occupancy 0, mispredict stays 0. Separately, assert cpu_rstn=0 in the cycle between a mismatch and its pulse -> mispredict never asserts and counters read 0.
